// File: rtl/key_search_scheduler.sv
// Dispatches a four-way split RC4 key search and collects the first winning core.
// Each core scans one quarter of the 2^SEARCH_BITS key space starting at its fixed base.
module key_search_scheduler #(
    parameter int KEY_W       = 24,
    parameter int SEARCH_BITS = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       core_done,
    input  logic [3:0]       core_found,
    input  logic [KEY_W-1:0] core_key_0,
    input  logic [KEY_W-1:0] core_key_1,
    input  logic [KEY_W-1:0] core_key_2,
    input  logic [KEY_W-1:0] core_key_3,
    output logic [3:0]       core_start,
    output logic [KEY_W-1:0] core_base_0,
    output logic [KEY_W-1:0] core_base_1,
    output logic [KEY_W-1:0] core_base_2,
    output logic [KEY_W-1:0] core_base_3,
    output logic [3:0]       core_abort,
    output logic [3:0]       success_state,
    output logic [KEY_W-1:0] secret_key,
    output logic             busy,
    output logic             found,
    output logic             failed,
    output logic [31:0]      search_cycles
);

    localparam int SHIFT = SEARCH_BITS - 2;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        FOUND,
        FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       done_mask_q, done_mask_d;
    logic [3:0]       success_q, success_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [31:0]      cycles_q, cycles_d;
    logic [3:0]       core_start_q, core_start_d;
    logic [3:0]       core_abort_q, core_abort_d;
    logic             busy_q, busy_d;
    logic             found_q, found_d;
    logic             failed_q, failed_d;

    logic [3:0]       hits;

    assign core_base_0 = '0;
    assign core_base_1 = KEY_W'(1) << SHIFT;
    assign core_base_2 = KEY_W'(2) << SHIFT;
    assign core_base_3 = KEY_W'(3) << SHIFT;

    // Only cores reporting for the first time in this search may claim the win.
    assign hits = core_done & core_found & ~done_mask_q;

    always_comb begin
        state_d     = state_q;
        done_mask_d = done_mask_q;
        success_d   = success_q;
        key_d       = key_q;
        cycles_d    = cycles_q;

        case (state_q)
            IDLE, FOUND, FAIL: begin
                if (start) begin
                    state_d     = LAUNCH;
                    done_mask_d = '0;
                    success_d   = '0;
                    key_d       = '0;
                    cycles_d    = '0;
                end
            end
            LAUNCH: begin
                state_d = RUN;
            end
            RUN: begin
                if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
                done_mask_d = done_mask_q | core_done;
                // Lowest index wins; a find always beats exhaustion in the same cycle.
                if (hits[0]) begin
                    success_d = 4'b0001;
                    key_d     = core_key_0;
                    state_d   = FOUND;
                end else if (hits[1]) begin
                    success_d = 4'b0010;
                    key_d     = core_key_1;
                    state_d   = FOUND;
                end else if (hits[2]) begin
                    success_d = 4'b0100;
                    key_d     = core_key_2;
                    state_d   = FOUND;
                end else if (hits[3]) begin
                    success_d = 4'b1000;
                    key_d     = core_key_3;
                    state_d   = FOUND;
                end else if (done_mask_d == 4'b1111) begin
                    state_d = FAIL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        core_start_d = (state_d == LAUNCH) ? 4'b1111 : 4'b0000;
        core_abort_d = (state_d == FOUND) ? ~success_d : 4'b0000;
        busy_d       = (state_d == LAUNCH) || (state_d == RUN);
        found_d      = (state_d == FOUND);
        failed_d     = (state_d == FAIL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            done_mask_q  <= '0;
            success_q    <= '0;
            key_q        <= '0;
            cycles_q     <= '0;
            core_start_q <= '0;
            core_abort_q <= '0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            failed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_mask_q  <= done_mask_d;
            success_q    <= success_d;
            key_q        <= key_d;
            cycles_q     <= cycles_d;
            core_start_q <= core_start_d;
            core_abort_q <= core_abort_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            failed_q     <= failed_d;
        end
    end

    assign core_start    = core_start_q;
    assign core_abort    = core_abort_q;
    assign success_state = success_q;
    assign secret_key    = key_q;
    assign busy          = busy_q;
    assign found         = found_q;
    assign failed        = failed_q;
    assign search_cycles = cycles_q;

endmodule

// File: tb/tb_key_search_scheduler.sv
// Self-checking bench for key_search_scheduler: directed vector table, async reset
// sequence and randomized traffic against a search-level reference model.
module tb_key_search_scheduler;

    localparam int KEY_W       = 24;
    localparam int SEARCH_BITS = 22;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       core_done;
    logic [3:0]       core_found;
    logic [KEY_W-1:0] key_in [4];
    logic [3:0]       core_start;
    logic [KEY_W-1:0] core_base_0, core_base_1, core_base_2, core_base_3;
    logic [3:0]       core_abort;
    logic [3:0]       success_state;
    logic [KEY_W-1:0] secret_key;
    logic             busy, found, failed;
    logic [31:0]      search_cycles;

    int errors = 0;
    int checks = 0;

    key_search_scheduler #(.KEY_W(KEY_W), .SEARCH_BITS(SEARCH_BITS)) dut (
        .clk(clk), .reset(reset), .start(start),
        .core_done(core_done), .core_found(core_found),
        .core_key_0(key_in[0]), .core_key_1(key_in[1]),
        .core_key_2(key_in[2]), .core_key_3(key_in[3]),
        .core_start(core_start),
        .core_base_0(core_base_0), .core_base_1(core_base_1),
        .core_base_2(core_base_2), .core_base_3(core_base_3),
        .core_abort(core_abort), .success_state(success_state),
        .secret_key(secret_key), .busy(busy), .found(found), .failed(failed),
        .search_cycles(search_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       cs;
        logic             busy;
        logic             fnd;
        logic             fl;
        logic [3:0]       ss;
        logic [KEY_W-1:0] key;
        logic [3:0]       ab;
        logic [31:0]      cyc;
    } outs_t;

    typedef struct {
        bit               st;
        logic [3:0]       d;
        logic [3:0]       f;
        logic [KEY_W-1:0] k0, k1, k2, k3;
        outs_t            exp;
    } vec_t;

    vec_t vecs[$];

    // Reference model: tracks the search as a phase, a set of reported cores and a winner.
    localparam int P_IDLE = 0, P_LAUNCH = 1, P_RUN = 2, P_FOUND = 3, P_FAIL = 4;
    int               m_phase;
    bit               m_reported [4];
    int               m_winner;
    logic [KEY_W-1:0] m_key;
    longint           m_cycles;

    function automatic void model_reset();
        m_phase  = P_IDLE;
        m_winner = -1;
        m_key    = '0;
        m_cycles = 0;
        foreach (m_reported[i]) m_reported[i] = 1'b0;
    endfunction

    function automatic void model_step(bit st, logic [3:0] d, logic [3:0] f,
                                       logic [KEY_W-1:0] k0, logic [KEY_W-1:0] k1,
                                       logic [KEY_W-1:0] k2, logic [KEY_W-1:0] k3);
        logic [KEY_W-1:0] keys [4];
        int all_in;
        keys = '{k0, k1, k2, k3};
        if (m_phase == P_LAUNCH) begin
            m_phase = P_RUN;
        end else if (m_phase == P_RUN) begin
            if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
            for (int i = 0; i < 4; i++) begin
                if (m_winner < 0 && d[i] && f[i] && !m_reported[i]) m_winner = i;
            end
            for (int i = 0; i < 4; i++) if (d[i]) m_reported[i] = 1'b1;
            all_in = 0;
            for (int i = 0; i < 4; i++) all_in += m_reported[i];
            if (m_winner >= 0) begin
                m_key   = keys[m_winner];
                m_phase = P_FOUND;
            end else if (all_in == 4) begin
                m_phase = P_FAIL;
            end
        end else if (st) begin
            model_reset();
            m_phase = P_LAUNCH;
        end
    endfunction

    function automatic outs_t model_outputs();
        outs_t o;
        o      = '0;
        o.cs   = (m_phase == P_LAUNCH) ? 4'hF : 4'h0;
        o.busy = (m_phase == P_LAUNCH) || (m_phase == P_RUN);
        o.fnd  = (m_phase == P_FOUND);
        o.fl   = (m_phase == P_FAIL);
        o.ss   = (m_winner >= 0) ? 4'(1 << m_winner) : 4'h0;
        o.key  = m_key;
        o.ab   = (m_phase == P_FOUND) ? ~o.ss : 4'h0;
        o.cyc  = m_cycles[31:0];
        return o;
    endfunction

    function automatic outs_t dut_outputs();
        return '{cs: core_start, busy: busy, fnd: found, fl: failed, ss: success_state,
                 key: secret_key, ab: core_abort, cyc: search_cycles};
    endfunction

    function automatic outs_t mk(logic [3:0] cs, logic b, logic fn, logic fl,
                                 logic [3:0] ss, logic [KEY_W-1:0] key,
                                 logic [3:0] ab, logic [31:0] cyc);
        return '{cs: cs, busy: b, fnd: fn, fl: fl, ss: ss, key: key, ab: ab, cyc: cyc};
    endfunction

    function automatic void add(bit st, logic [3:0] d, logic [3:0] f,
                                logic [KEY_W-1:0] k0, logic [KEY_W-1:0] k1,
                                logic [KEY_W-1:0] k2, logic [KEY_W-1:0] k3, outs_t exp);
        vec_t v;
        v.st = st; v.d = d; v.f = f;
        v.k0 = k0; v.k1 = k1; v.k2 = k2; v.k3 = k3;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check_output(string name, outs_t got, outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got cs=%h busy=%b found=%b failed=%b ss=%h key=%h abort=%h cyc=%0d, expected cs=%h busy=%b found=%b failed=%b ss=%h key=%h abort=%h cyc=%0d",
                     name, got.cs, got.busy, got.fnd, got.fl, got.ss, got.key, got.ab, got.cyc,
                     exp.cs, exp.busy, exp.fnd, exp.fl, exp.ss, exp.key, exp.ab, exp.cyc);
        end
    endtask

    task automatic check_value(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge.
    task automatic apply_stimulus(bit st, logic [3:0] d, logic [3:0] f,
                                  logic [KEY_W-1:0] k0, logic [KEY_W-1:0] k1,
                                  logic [KEY_W-1:0] k2, logic [KEY_W-1:0] k3);
        start      = st;
        core_done  = d;
        core_found = f;
        key_in[0]  = k0; key_in[1] = k1; key_in[2] = k2; key_in[3] = k3;
        @(posedge clk);
        model_step(st, d, f, k0, k1, k2, k3);
        @(negedge clk);
    endtask

    task automatic idle_step(bit st);
        apply_stimulus(st, 4'h0, 4'h0, '0, '0, '0, '0);
    endtask

    initial begin
        outs_t zero;
        zero = '0;
        model_reset();
        reset = 1'b1;
        start = 1'b0;
        core_done = '0;
        core_found = '0;
        foreach (key_in[i]) key_in[i] = '0;
        @(negedge clk);
        @(negedge clk);
        check_output("reset_state", dut_outputs(), zero);
        reset = 1'b0;

        check_value("core_base_0", 32'(core_base_0), 32'h000000);
        check_value("core_base_1", 32'(core_base_1), 32'h100000);
        check_value("core_base_2", 32'(core_base_2), 32'h200000);
        check_value("core_base_3", 32'(core_base_3), 32'h300000);

        // Launch, ten quiet RUN cycles, then core 2 finds the key.
        add(0, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0));
        add(1, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'hF, 1, 0, 0, 4'h0, 0, 4'h0, 0));
        add(0, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 0));
        for (int i = 1; i <= 10; i++)
            add(0, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'h0, 1, 0, 0, 4'h0, 0, 4'h0, i));
        add(0, 4'h4, 4'h4, 0, 0, 24'h2ABCDE, 0, mk(4'h0, 0, 1, 0, 4'h4, 24'h2ABCDE, 4'hB, 11));
        add(0, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'h0, 0, 1, 0, 4'h4, 24'h2ABCDE, 4'hB, 11));
        // Start in FOUND relaunches, start held through RUN is ignored, two simultaneous finds.
        add(1, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'hF, 1, 0, 0, 4'h0, 0, 4'h0, 0));
        add(1, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 0));
        add(1, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 1));
        add(0, 4'hA, 4'hA, 0, 24'h100001, 0, 24'h300002, mk(4'h0, 0, 1, 0, 4'h2, 24'h100001, 4'hD, 2));
        add(0, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'h0, 0, 1, 0, 4'h2, 24'h100001, 4'hD, 2));
        // Exhaustion with a repeated report from core 0.
        add(1, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'hF, 1, 0, 0, 4'h0, 0, 4'h0, 0));
        add(0, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 0));
        add(0, 4'h1, 4'h0, 0, 0, 0, 0, mk(4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 1));
        add(0, 4'h1, 4'h0, 0, 0, 0, 0, mk(4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 2));
        add(0, 4'h4, 4'h0, 0, 0, 0, 0, mk(4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 3));
        add(0, 4'h1, 4'h0, 0, 0, 0, 0, mk(4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 4));
        add(0, 4'h8, 4'h0, 0, 0, 0, 0, mk(4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 5));
        add(0, 4'h2, 4'h0, 0, 0, 0, 0, mk(4'h0, 0, 0, 1, 4'h0, 0, 4'h0, 6));
        add(0, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'h0, 0, 0, 1, 4'h0, 0, 4'h0, 6));
        add(0, 4'hF, 4'hF, 24'h11, 24'h22, 24'h33, 24'h44, mk(4'h0, 0, 0, 1, 4'h0, 0, 4'h0, 6));
        // Pulses during LAUNCH must not count toward the done mask.
        add(1, 4'h0, 4'h0, 0, 0, 0, 0, mk(4'hF, 1, 0, 0, 4'h0, 0, 4'h0, 0));
        add(0, 4'hF, 4'h0, 0, 0, 0, 0, mk(4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 0));
        add(0, 4'h1, 4'h1, 24'h000123, 0, 0, 0, mk(4'h0, 0, 1, 0, 4'h1, 24'h000123, 4'hE, 1));
        add(0, 4'h1, 4'h1, 24'h000777, 0, 0, 0, mk(4'h0, 0, 1, 0, 4'h1, 24'h000123, 4'hE, 1));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].st, vecs[i].d, vecs[i].f,
                           vecs[i].k0, vecs[i].k1, vecs[i].k2, vecs[i].k3);
            check_output($sformatf("vec%0d", i), dut_outputs(), vecs[i].exp);
            check_output($sformatf("vec%0d_model", i), dut_outputs(), model_outputs());
        end

        // Asynchronous reset in the middle of a RUN cycle.
        idle_step(1);
        idle_step(0);
        idle_step(0);
        idle_step(0);
        check_value("pre_reset_cycles", search_cycles, 32'd2);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_output("async_reset", dut_outputs(), zero);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_step(0);
        idle_step(0);
        check_output("idle_after_reset", dut_outputs(), zero);
        idle_step(1);
        check_output("relaunch", dut_outputs(), mk(4'hF, 1, 0, 0, 4'h0, 0, 4'h0, 0));
        idle_step(0);
        idle_step(0);
        check_output("cycles_restart", dut_outputs(), mk(4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 1));
        check_output("cycles_restart_model", dut_outputs(), model_outputs());

        for (int n = 0; n < 800; n++) begin
            bit               st;
            logic [3:0]       d, f;
            logic [KEY_W-1:0] k [4];
            st = ($urandom_range(0, 5) == 0);
            for (int b = 0; b < 4; b++) begin
                d[b] = ($urandom_range(0, 7) == 0);
                f[b] = ($urandom_range(0, 5) == 0);
                k[b] = KEY_W'($urandom);
            end
            apply_stimulus(st, d, f, k[0], k[1], k[2], k[3]);
            check_output($sformatf("rand%0d", n), dut_outputs(), model_outputs());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
